// File: rtl/next_pc_btb_if.sv
// Fetch-side bus of the next-PC branch target buffer.
// The master drives lookup and update inputs; the slave (BTB) returns npc, pred_taken and flush.
interface next_pc_btb_if;
   logic [31:0] pc;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic [31:0] npc;
   logic        pred_taken;
   logic        flush;

   modport master (
      output pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
      input  npc, pred_taken, flush
   );

   modport slave (
      input  pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
      output npc, pred_taken, flush
   );
endinterface

// File: rtl/next_pc_btb.sv
// 8-entry direct-mapped BTB with 2-bit counters and zero-cycle next-PC selection.
// Defining BTB_STATS_EN adds registered hit_cnt / mispred_cnt counters.
module next_pc_btb (
   input  logic          clk,
   input  logic          rst,
   next_pc_btb_if.slave  bus
`ifdef BTB_STATS_EN
   ,
   output logic [31:0]   hit_cnt,
   output logic [31:0]   mispred_cnt
`endif
);

   logic        valid_q  [8];
   logic [26:0] tag_q    [8];
   logic [31:0] target_q [8];
   logic [1:0]  ctr_q    [8];

   logic [2:0]  idx;
   logic [26:0] tag;
   logic        hit;
   logic        pred;
   logic [2:0]  upd_idx;
   logic [26:0] upd_tag;
   logic        upd_hit;
   logic        mispredict;
   logic [31:0] pc_plus4;
   logic [31:0] upd_pc_plus4;
   logic        unused_low_bits;

   assign unused_low_bits = ^{bus.pc[1:0], bus.upd_pc[1:0]};

   assign idx  = bus.pc[4:2];
   assign tag  = bus.pc[31:5];
   assign hit  = valid_q[idx] && (tag_q[idx] == tag);
   assign pred = hit && ctr_q[idx][1];

   assign upd_idx = bus.upd_pc[4:2];
   assign upd_tag = bus.upd_pc[31:5];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   assign mispredict = bus.upd_en &&
                       ((bus.upd_taken != bus.upd_pred_taken) ||
                        (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

   assign pc_plus4     = bus.pc + 32'd4;
   assign upd_pc_plus4 = bus.upd_pc + 32'd4;

   // Redirect from EX outranks the fetch-stage prediction.
   always_comb begin
      bus.npc = pc_plus4;
      if (mispredict && bus.upd_taken)
         bus.npc = bus.upd_target;
      else if (mispredict)
         bus.npc = upd_pc_plus4;
      else if (pred)
         bus.npc = target_q[idx];
   end

   assign bus.pred_taken = pred;
   assign bus.flush      = mispredict;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b00;
         end
      end else if (bus.upd_en) begin
         if (upd_hit) begin
            if (bus.upd_taken && ctr_q[upd_idx] != 2'b11)
               ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
            else if (!bus.upd_taken && ctr_q[upd_idx] != 2'b00)
               ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
         end else if (bus.upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target carry no reset; valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (!rst && bus.upd_en && bus.upd_taken) begin
         target_q[upd_idx] <= bus.upd_target;
         if (!upd_hit)
            tag_q[upd_idx] <= upd_tag;
      end
   end

`ifdef BTB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt     <= '0;
         mispred_cnt <= '0;
      end else begin
         if (hit)
            hit_cnt <= hit_cnt + 32'd1;
         if (mispredict)
            mispred_cnt <= mispred_cnt + 32'd1;
      end
   end
`endif

endmodule
